// File: rtl/lsu_unit.sv
// ============================================================================
// Module   : lsu_unit
// Purpose  : RISC-V load/store unit with a request/grant/response memory port,
//            byte-lane store formation and sign/zero-extended load return.
//            Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses
//            into an immediate trap completion instead of a memory access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  wb_valid,
    output logic                  misaligned,
    output logic                  stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   sdata_q, sdata_d;
    logic [2:0]              f3_q, f3_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;

    // Funct3[1:0] alone selects the size: 00 byte, 01 half, anything else word.
    logic                    w_is_byte;
    logic                    w_is_half;
    logic                    w_signed;
    logic [1:0]              w_off;
    logic [3:0]              w_store_be;
    logic [DATA_WIDTH-1:0]   w_store_data;
    logic [7:0]              w_ld_byte;
    logic [15:0]             w_ld_half;
    logic [DATA_WIDTH-1:0]   w_ld_ext;
    logic                    w_accept;

    assign w_is_byte = (f3_q[1:0] == 2'b00);
    assign w_is_half = (f3_q[1:0] == 2'b01);
    assign w_signed  = ~f3_q[2];
    assign w_accept  = ex_valid & ex_ready & (MemRead | MemWrite);

    // Halves only use the upper/lower half-word; words always sit at lane 0.
    always_comb begin
        w_off = 2'b00;
        if (w_is_byte) begin
            w_off = addr_q[1:0];
        end else if (w_is_half) begin
            w_off = {addr_q[1], 1'b0};
        end
    end

    always_comb begin
        w_store_be   = 4'b1111;
        w_store_data = sdata_q;
        if (w_is_byte) begin
            w_store_be   = 4'b0001 << w_off;
            w_store_data = {4{sdata_q[7:0]}};
        end else if (w_is_half) begin
            w_store_be   = 4'b0011 << w_off;
            w_store_data = {2{sdata_q[15:0]}};
        end
    end

    always_comb begin
        w_ld_byte = mem_rdata[7:0];
        case (w_off)
            2'd1:    w_ld_byte = mem_rdata[15:8];
            2'd2:    w_ld_byte = mem_rdata[23:16];
            2'd3:    w_ld_byte = mem_rdata[31:24];
            default: w_ld_byte = mem_rdata[7:0];
        endcase
        w_ld_half = w_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (w_is_byte) begin
            w_ld_ext = {{24{w_signed & w_ld_byte[7]}}, w_ld_byte};
        end else if (w_is_half) begin
            w_ld_ext = {{16{w_signed & w_ld_half[15]}}, w_ld_half};
        end else begin
            w_ld_ext = mem_rdata;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal_q, misal_d;
    logic w_misal;

    assign w_misal = ((Funct3[1:0] == 2'b01) & ALUResult[0]) |
                     ((Funct3[1] == 1'b1) & (ALUResult[1:0] != 2'b00));
    assign misaligned = (state_q == S_DONE) & misal_q;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        f3_d        = f3_q;
        we_d        = we_q;
        load_data_d = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misal_d     = misal_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    addr_d  = ALUResult;
                    sdata_d = StoreData;
                    f3_d    = Funct3;
                    we_d    = ~MemRead;
`ifdef LSU_MISALIGN_TRAP_EN
                    misal_d = w_misal;
                    state_d = w_misal ? S_DONE : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    load_data_d = w_ld_ext;
                    state_d     = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sdata_q     <= '0;
            f3_q        <= 3'b000;
            we_q        <= 1'b0;
            load_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misal_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            f3_q        <= f3_d;
            we_q        <= we_d;
            load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misal_q     <= misal_d;
`endif
        end
    end

    assign ex_ready  = (state_q == S_IDLE);
    assign stall     = (state_q != S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? (we_q ? w_store_be : 4'b1111) : 4'b0000;
    assign mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign mem_wdata = w_store_data;
    assign LoadData  = load_data_q;
    assign wb_valid  = (state_q == S_DONE);

endmodule

`default_nettype wire
